data_mem_subword: RTL and testbench
===================================

DATA_MEM_SUBWORD -- requirements
Module: data_mem_subword

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LAT, default 1, load latency in cycles; legal values are 1, 2 and 3.
REQ-003 SHALL have parameter INIT_EN, default 1; 1 = preload words 0..3 at time zero.
REQ-004 SHALL have port Clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  in  1  access request, sampled each rising edge.
REQ-007 SHALL have port we  in  1  1 = store, 0 = load; ignored while req=0.
REQ-008 SHALL have port size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port uns  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 SHALL have port addr  in  ADDR_W+2  byte address.
REQ-011 SHALL have port wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port rdata  out  32  load result, right-aligned and extended.
REQ-013 SHALL have port rvalid  out  1  one-cycle pulse marking rdata valid.
REQ-014 SHALL have port err  out  1  one-cycle pulse for a misaligned or reserved-size access.

Function
REQ-015 SHALL accept one request per cycle with no back-pressure; word index = addr[ADDR_W+1:2], lane = addr[1:0].
REQ-016 SHALL classify an access as illegal when any of these hold: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
REQ-017 SHALL write stores at the accepting edge with per-lane enables:
- byte: writes wdata[7:0] into lane addr[1:0].
- half: writes wdata[15:0] into lanes 0-1 when addr[1]=0, lanes 2-3 when addr[1]=1.
- word: writes all four lanes.
- all other lanes of the word stay unchanged.
REQ-018 SHALL NOT write memory for an illegal store.
REQ-019 SHALL read the addressed word at the accepting edge, then carry it with size, lane and uns through a LAT-stage shift pipeline.
REQ-020 SHALL assert rvalid exactly LAT cycles after the accepting edge of a legal load, for one cycle.
REQ-021 SHALL format rdata in that same cycle: selected byte/half extended per uns, or the full word.
REQ-022 SHALL pulse err for one cycle, LAT cycles after an illegal access (load or store); rvalid SHALL stay 0 for that access.
REQ-023 SHALL hold rdata at its last value while rvalid=0.
REQ-024 SHALL NOT produce rvalid for a store.
REQ-025 SHALL return the stored data to a load accepted in any cycle after the store to the same word; no stale data.
REQ-026 SHALL allow back-to-back loads with rvalid pulses in consecutive cycles, each pulse in request order.
REQ-027 SHALL make no output change for a cycle with req=0, except draining the pipeline.
REQ-028 SHALL wrap addresses modulo depth, with no out-of-range error; only the ADDR_W+2 bits of addr are used.

Reset
REQ-029 SHALL, while rst=1, force rdata=0, rvalid=0, err=0, clear all pipeline stages and ignore req.
REQ-030 SHALL discard in-flight loads when rst asserts mid-operation: no rvalid or err pulse for them after release.
REQ-031 SHALL NOT clear memory contents with rst.
REQ-032 SHALL, when INIT_EN=1, preload at time zero: word0=2001, word1=4001, word2=5001, word3=3001 (decimal); all other words SHALL be 0.

Verification
REQ-033 SHALL be covered: after reset, word loads of addr 0, 4, 8, 12 with LAT=1 -> rvalid one cycle later with rdata 2001, 4001, 5001, 3001.
REQ-034 SHALL be covered: word store 0x11223344 to addr 16, byte store 0xAA to addr 17, then signed byte load addr 17 -> rdata 0xFFFFFFAA; unsigned half load addr 16 -> 0x0000AA44.
REQ-035 SHALL be covered: half load addr 18 of word 0x80010000, uns=0 -> 0xFFFF8001; uns=1 -> 0x00008001.
REQ-036 SHALL be covered: word store to addr 21 -> err pulse, no rvalid, word 5 unchanged on readback; size=11 load -> err only.
REQ-037 SHALL be covered: LAT=3, four back-to-back loads -> four consecutive rvalid pulses starting 3 cycles after the first request, in order.
REQ-038 SHALL be covered: rst asserted one cycle after a load with LAT=2 -> no rvalid after release; memory retains prior stores.

Source files
------------

// File: rtl/data_mem_subword.sv
// data_mem_subword: byte-addressed 32-bit data memory with byte/half/word access and a LAT-cycle load pipeline.
module data_mem_subword #(
  parameter int ADDR_W = 10,
  parameter int LAT = 1,
  parameter bit INIT_EN = 1
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef struct packed {
    logic        v;
    logic        e;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic        uns;
    logic [31:0] word;
  } stage_t;
  logic [31:0] mem [DEPTH] = '{
    0: INIT_EN ? 32'd2001 : 32'd0,
    1: INIT_EN ? 32'd4001 : 32'd0,
    2: INIT_EN ? 32'd5001 : 32'd0,
    3: INIT_EN ? 32'd3001 : 32'd0,
    default: 32'd0
  };
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic              ill;
  logic              wr;
  logic [3:0]        be;
  logic [31:0]       wd;
  stage_t            st_d [LAT];
  stage_t            st_q [LAT];
  stage_t            o;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [31:0]       rdata_d;
  logic [31:0]       rdata_q;
  always_comb begin
    widx = addr[ADDR_W+1:2];
    lane = addr[1:0];
    ill = size == 2'b11 || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
    wr = req && we && !ill && !rst;
    be = size == 2'b00 ? 4'b0001 << lane : size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    st_d[0] = '{v: req && !we && !ill, e: req && ill, size: size, lane: lane, uns: uns, word: mem[widx]};
    for (int i = 1; i < LAT; i++) st_d[i] = st_q[i-1];
    // Format on entry to the last stage so rdata_q lines up with rvalid.
    o = st_d[LAT-1];
    b = 8'(o.word >> {o.lane, 3'b000});
    h = o.lane[1] ? o.word[31:16] : o.word[15:0];
    rdata_d = !o.v ? rdata_q
            : o.size == 2'b00 ? {{24{!o.uns && b[7]}}, b}
            : o.size == 2'b01 ? {{16{!o.uns && h[15]}}, h}
            : o.word;
  end
  always_ff @(posedge Clk or posedge rst)
    if (rst) begin
      st_q <= '{default: '0};
      rdata_q <= '0;
    end else begin
      st_q <= st_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge Clk)
    for (int i = 0; i < 4; i++)
      if (wr && be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
  assign rdata = rdata_q;
  assign rvalid = st_q[LAT-1].v;
  assign err = st_q[LAT-1].e;
endmodule

// File: tb/tb_data_mem_subword.sv
// tb_data_mem_subword: table-driven and random scoreboard bench for data_mem_subword at LAT 1, 2 and 3.
module tb_data_mem_subword;
  localparam int AW = 10;
  typedef struct {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [AW+1:0] addr;
    logic [31:0] wdata;
    logic [1:0]  kind;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    int          due;
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;
  logic          Clk = 0, rst = 1, req = 0, we = 0, uns = 0;
  logic [1:0]    size = 0;
  logic [AW+1:0] addr = 0;
  logic [31:0]   wdata = 0;
  logic [2:0][31:0] rdata_o;
  logic [2:0]    rvalid_o, err_o;
  ev_t           sb [3][$];
  logic [31:0]   last [3];
  logic [7:0]    mb [4 << AW];
  vec_t          tv [$];
  int            cyc = 0, total = 0, bad = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_subword #(.ADDR_W(AW), .LAT(g + 1), .INIT_EN(1)) dut (
      .Clk(Clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .rdata(rdata_o[g]), .rvalid(rvalid_o[g]), .err(err_o[g])
    );
  end

  function automatic vec_t vec(logic r, logic w, logic [1:0] s, logic u, int a, logic [31:0] d,
                               logic [1:0] k, logic [31:0] e);
    vec_t v;
    v.req = r; v.we = w; v.size = s; v.uns = u; v.addr = (AW+2)'(a);
    v.wdata = d; v.kind = k; v.exp = e;
    return v;
  endfunction

  function automatic logic illegal(logic [1:0] s, logic [AW+1:0] a);
    return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mload(logic [1:0] s, logic u, logic [AW+1:0] a);
    int ai = int'(a);
    logic [15:0] hw;
    if (s == 2'd0) return u ? {24'h0, mb[ai]} : {{24{mb[ai][7]}}, mb[ai]};
    hw = {mb[ai+1], mb[ai]};
    if (s == 2'd1) return u ? {16'h0, hw} : {{16{hw[15]}}, hw};
    return {mb[ai+3], mb[ai+2], hw};
  endfunction

  task automatic mstore(logic [1:0] s, logic [AW+1:0] a, logic [31:0] d);
    int n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    for (int i = 0; i < n; i++) mb[int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic chk(string n, int k, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", n, k + 1, cyc, a, e);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [1:0]  kd;
      logic [31:0] d;
      ev_t         ev;
      kd = 0;
      d = last[k];
      if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
        ev = sb[k].pop_front();
        kd = ev.kind;
        if (kd == 2'd1) d = ev.data;
      end
      chk("rvalid", k, 32'(rvalid_o[k]), 32'(kd == 2'd1));
      chk("err", k, 32'(err_o[k]), 32'(kd == 2'd2));
      chk("rdata", k, rdata_o[k], d);
      last[k] = d;
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    check_all();
  endtask

  task automatic issue(vec_t v);
    req = v.req; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    for (int k = 0; k < 3; k++)
      if (v.kind != 2'd0) sb[k].push_back('{cyc + k + 1, v.kind, v.exp});
    if (v.req && v.we && v.kind == 2'd0) mstore(v.size, v.addr, v.wdata);
    cycle();
    req = 0;
    we = 0;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < (4 << AW); i++) mb[i] = 8'h0;
    mstore(2'd2, 0, 32'd2001);
    mstore(2'd2, 4, 32'd4001);
    mstore(2'd2, 8, 32'd5001);
    mstore(2'd2, 12, 32'd3001);
    for (int k = 0; k < 3; k++) last[k] = 32'h0;
    // kind: 0 = no event, 1 = rvalid with exp, 2 = err pulse
    tv.push_back(vec(1, 0, 2, 0, 0,    0, 1, 32'd2001));
    tv.push_back(vec(1, 0, 2, 0, 4,    0, 1, 32'd4001));
    tv.push_back(vec(1, 0, 2, 0, 8,    0, 1, 32'd5001));
    tv.push_back(vec(1, 0, 2, 0, 12,   0, 1, 32'd3001));
    tv.push_back(vec(1, 1, 2, 0, 16,   32'h11223344, 0, 0));
    tv.push_back(vec(1, 1, 0, 0, 17,   32'h123456AA, 0, 0));
    tv.push_back(vec(1, 0, 0, 0, 17,   0, 1, 32'hFFFFFFAA));
    tv.push_back(vec(1, 0, 1, 1, 16,   0, 1, 32'h0000AA44));
    tv.push_back(vec(1, 1, 2, 0, 16,   32'h80010000, 0, 0));
    tv.push_back(vec(1, 0, 1, 0, 18,   0, 1, 32'hFFFF8001));
    tv.push_back(vec(1, 0, 1, 1, 18,   0, 1, 32'h00008001));
    tv.push_back(vec(0, 0, 0, 0, 0,    0, 0, 0));
    tv.push_back(vec(1, 1, 2, 0, 21,   32'hDEADBEEF, 2, 0));
    tv.push_back(vec(1, 0, 2, 0, 20,   0, 1, 32'h0));
    tv.push_back(vec(1, 0, 3, 0, 0,    0, 2, 0));
    tv.push_back(vec(1, 0, 0, 0, 0,    0, 1, 32'hFFFFFFD1));
    tv.push_back(vec(1, 0, 0, 1, 1,    0, 1, 32'h00000007));
    tv.push_back(vec(1, 0, 1, 0, 1,    0, 2, 0));
    tv.push_back(vec(1, 1, 1, 0, 10,   32'h5555BEEF, 0, 0));
    tv.push_back(vec(1, 0, 2, 0, 8,    0, 1, 32'hBEEF1389));
    tv.push_back(vec(1, 0, 1, 0, 10,   0, 1, 32'hFFFFBEEF));
    tv.push_back(vec(1, 0, 1, 0, 8,    0, 1, 32'h00001389));
    tv.push_back(vec(1, 0, 2, 0, 4092, 0, 1, 32'h0));
    tv.push_back(vec(1, 1, 0, 0, 4095, 32'h00000080, 0, 0));
    tv.push_back(vec(1, 0, 0, 0, 4095, 0, 1, 32'hFFFFFF80));
    tv.push_back(vec(1, 0, 2, 0, 4092, 0, 1, 32'h80000000));
    tv.push_back(vec(0, 1, 2, 0, 0,    32'hFFFFFFFF, 0, 0));
    tv.push_back(vec(1, 0, 2, 0, 0,    0, 1, 32'd2001));
    repeat (2) cycle();
    rst = 0;
    cycle();
    foreach (tv[i]) issue(tv[i]);
    repeat (4) cycle();
    // reset one cycle after a load: LAT 2/3 results must vanish, a store held during reset must not land
    issue(vec(1, 0, 2, 0, 16, 0, 1, mload(2'd2, 0, 12'd16)));
    rst = 1;
    req = 1; we = 1; size = 2'd2; addr = 12'd16; wdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      sb[k].delete();
      last[k] = 32'h0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rvalid", k, 32'(rvalid_o[k]), 0);
      chk("rst_err", k, 32'(err_o[k]), 0);
      chk("rst_rdata", k, rdata_o[k], 0);
    end
    repeat (2) cycle();
    rst = 0; req = 0; we = 0;
    repeat (4) cycle();
    issue(vec(1, 0, 2, 0, 16, 0, 1, mload(2'd2, 0, 12'd16)));
    issue(vec(1, 0, 1, 1, 18, 0, 1, mload(2'd1, 1, 12'd18)));
    repeat (4) cycle();
    for (int n = 0; n < 80; n++) begin
      v.req = $urandom_range(0, 3) != 0;
      v.we = 1'($urandom_range(0, 1));
      v.size = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.addr = $urandom_range(0, 7) == 0 ? (AW+2)'($urandom)
             : (AW+2)'({3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
      v.wdata = $urandom;
      v.kind = !v.req ? 2'd0 : illegal(v.size, v.addr) ? 2'd2 : v.we ? 2'd0 : 2'd1;
      v.exp = v.kind == 2'd1 ? mload(v.size, v.uns, v.addr) : 32'h0;
      issue(v);
    end
    repeat (5) cycle();
    for (int k = 0; k < 3; k++) chk("sb_empty", k, 32'(sb[k].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
